// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for the 4-6-5-3 MLP classifier. Walks every neuron of
// every layer through bias-load, one MAC per input, and writeback on a single
// shared MAC datapath, producing flat weight/bias ROM addresses.
module mlp_layer_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_H1   = 6,
  parameter int N_H2   = 5,
  parameter int N_OUT  = 3,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        layer_o,
  output logic [IDX_W-1:0]  neuron_o,
  output logic [IDX_W-1:0]  input_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              wb_en_o,
  output logic              relu_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIAS = 3'd1,
    S_MAC  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // ROM layout: weights of each layer packed back to back, row-major by
  // destination neuron; biases likewise.
  localparam logic [ADDR_W-1:0] WBASE1 = ADDR_W'(N_IN * N_H1);
  localparam logic [ADDR_W-1:0] WBASE2 = ADDR_W'(N_IN * N_H1 + N_H1 * N_H2);
  localparam logic [ADDR_W-1:0] BBASE1 = ADDR_W'(N_H1);
  localparam logic [ADDR_W-1:0] BBASE2 = ADDR_W'(N_H1 + N_H2);

  state_e            state_q, state_d;
  logic [1:0]        layer_q, layer_d;
  logic [IDX_W-1:0]  neuron_q, neuron_d;
  logic [IDX_W-1:0]  input_q, input_d;

  logic [IDX_W-1:0]  fanin, fanout;
  logic [ADDR_W-1:0] wbase, bbase;
  logic              run_st;

  // Per-layer geometry selected by the current layer counter.
  always_comb begin
    fanin  = IDX_W'(N_IN);
    fanout = IDX_W'(N_H1);
    wbase  = '0;
    bbase  = '0;
    case (layer_q)
      2'd1: begin
        fanin  = IDX_W'(N_H1);
        fanout = IDX_W'(N_H2);
        wbase  = WBASE1;
        bbase  = BBASE1;
      end
      2'd2: begin
        fanin  = IDX_W'(N_H2);
        fanout = IDX_W'(N_OUT);
        wbase  = WBASE2;
        bbase  = BBASE2;
      end
      default: ;
    endcase
  end

  // State and counter registers; reset lands in IDLE with counters cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      input_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      input_q  <= input_d;
    end
  end

  // Next-state and counter sequencing; stall holds everything in BIAS/MAC/WB.
  always_comb begin
    // NOTE: hold-current defaults on every path keep this block free of latches.
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    input_d  = input_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_BIAS;
          layer_d  = '0;
          neuron_d = '0;
          input_d  = '0;
        end
      end
      S_BIAS: begin
        if (!stall_i) begin
          state_d = S_MAC;
          input_d = '0;
        end
      end
      S_MAC: begin
        if (!stall_i) begin
          if (input_q < fanin - 1'b1) input_d = input_q + 1'b1;
          else                        state_d = S_WB;
        end
      end
      S_WB: begin
        if (!stall_i) begin
          if (neuron_q < fanout - 1'b1) begin
            neuron_d = neuron_q + 1'b1;
            input_d  = '0;
            state_d  = S_BIAS;
          end else if (layer_q < 2'd2) begin
            layer_d  = layer_q + 1'b1;
            neuron_d = '0;
            input_d  = '0;
            state_d  = S_BIAS;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Return to a clean idle so addresses read 0 between runs.
        state_d  = S_IDLE;
        layer_d  = '0;
        neuron_d = '0;
        input_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run_st    = (state_q == S_BIAS) || (state_q == S_MAC) || (state_q == S_WB);
  assign busy_o    = run_st;
  assign done_o    = (state_q == S_DONE);
  assign layer_o   = layer_q;
  assign neuron_o  = neuron_q;
  assign input_o   = input_q;
  assign b_addr_o  = bbase + ADDR_W'(neuron_q);
  assign w_addr_o  = wbase + ADDR_W'(neuron_q) * ADDR_W'(fanin) + ADDR_W'(input_q);
  assign mac_clr_o = (state_q == S_BIAS) && !stall_i;
  assign mac_en_o  = (state_q == S_MAC)  && !stall_i;
  assign wb_en_o   = (state_q == S_WB)   && !stall_i;
  assign relu_o    = (state_q == S_WB)   && (layer_q != 2'd2);

endmodule
